mips_pipeline_idex_register: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core. It captures the packed IdEx pipeline word built by the ID-stage generator and presents it to EX on the next clock.
- Contains load-use hazard detection. It inserts a bubble and stalls IF/ID when needed.
- Honours flush (taken branch/jump resolved downstream) and hold (downstream multi-cycle stall).
- Keeps a saturating bubble counter for performance debug.

---
 rtl/mips_pipeline_idex_register_pkg.sv | 9 +
 rtl/mips_hazard_load_use.sv | 16 +
 rtl/mips_pipeline_idex_register.sv | 60 ++++++
 tb/tb_mips_pipeline_idex_register.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_pipeline_idex_register_pkg.sv
// mips_pipeline_idex_register_pkg: shared IdEx word width, register constants and valid/load convention
package mips_pipeline_idex_register_pkg;
   localparam int IDEX_W = 160;
   localparam logic [4:0] REG_ZERO = 5'd0;
   // A load flag is only meaningful alongside a real instruction.
   function automatic logic load_flag(input logic valid, input logic mem_read);
      return valid & mem_read;
   endfunction
endpackage

// File: rtl/mips_hazard_load_use.sv
// mips_hazard_load_use: detects an ID instruction reading the destination of a load sitting in EX
module mips_hazard_load_use
   import mips_pipeline_idex_register_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_dest,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       hazard
);
   assign hazard = ex_valid & ex_mem_read & id_valid & (ex_dest != REG_ZERO) &
                   ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
endmodule

// File: rtl/mips_pipeline_idex_register.sv
// mips_pipeline_idex_register: ID/EX register with load-use bubble insertion, flush, hold and bubble counter
module mips_pipeline_idex_register
   import mips_pipeline_idex_register_pkg::*;
#(
   parameter int PIPE_W = IDEX_W,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PIPE_W-1:0] pipeIn,
   input  logic              idValid,
   input  logic [4:0]        idRs,
   input  logic [4:0]        idRt,
   input  logic              idUsesRt,
   input  logic              idMemRead,
   input  logic [4:0]        idDestReg,
   input  logic              flush,
   input  logic              hold,
   output logic [PIPE_W-1:0] pipeOut,
   output logic              exValid,
   output logic              exMemRead,
   output logic [4:0]        exDestReg,
   output logic              stallIfId,
   output logic [CNT_W-1:0]  bubbleCount
);
   logic hazard;
   mips_hazard_load_use u_hazard (
      .ex_valid   (exValid),
      .ex_mem_read(exMemRead),
      .ex_dest    (exDestReg),
      .id_valid   (idValid),
      .id_rs      (idRs),
      .id_rt      (idRt),
      .id_uses_rt (idUsesRt),
      .hazard     (hazard)
   );
   assign stallIfId = hazard | hold;
   always_ff @(posedge clock) begin
      if (reset) begin
         pipeOut     <= '0;
         exValid     <= 1'b0;
         exMemRead   <= 1'b0;
         exDestReg   <= REG_ZERO;
         bubbleCount <= '0;
      end else if (flush || (hazard && !hold)) begin
         pipeOut   <= '0;
         exValid   <= 1'b0;
         exMemRead <= 1'b0;
         exDestReg <= REG_ZERO;
         // Squashed instructions are not load-use bubbles; only count the hazard path.
         if (!flush)
            bubbleCount <= &bubbleCount ? bubbleCount : bubbleCount + 1'b1;
      end else if (!hold) begin
         pipeOut   <= pipeIn;
         exValid   <= idValid;
         exMemRead <= load_flag(idValid, idMemRead);
         exDestReg <= idValid ? idDestReg : REG_ZERO;
      end
   end
endmodule

// File: tb/tb_mips_pipeline_idex_register.sv
// tb_mips_pipeline_idex_register: directed vectors for the ID/EX register with hand-computed expectations
module tb_mips_pipeline_idex_register;
   localparam int PW = 160;
   localparam int CW = 4;
   logic          clock = 1'b0;
   logic          reset, idValid, idUsesRt, idMemRead, flush, hold;
   logic [PW-1:0] pipeIn, pipeOut;
   logic [4:0]    idRs, idRt, idDestReg, exDestReg;
   logic          exValid, exMemRead, stallIfId;
   logic [CW-1:0] bubbleCount;
   int            checks = 0;
   int            failures = 0;
   logic [PW-1:0] p1, p2, p3, p4, p5;

   mips_pipeline_idex_register #(.PIPE_W(PW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .pipeIn(pipeIn), .idValid(idValid),
      .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt), .idMemRead(idMemRead),
      .idDestReg(idDestReg), .flush(flush), .hold(hold), .pipeOut(pipeOut),
      .exValid(exValid), .exMemRead(exMemRead), .exDestReg(exDestReg),
      .stallIfId(stallIfId), .bubbleCount(bubbleCount)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic present(input logic [PW-1:0] p, input logic ld, input logic [4:0] dst,
                          input logic [4:0] rs, input logic [4:0] rt, input logic urt);
      pipeIn = p; idValid = 1'b1; idMemRead = ld; idDestReg = dst;
      idRs = rs; idRt = rt; idUsesRt = urt;
      #1;
   endtask

   initial begin
      p1 = {5{32'hA5A5_A5A5}};
      p2 = {5{32'h1234_5678}};
      p3 = {5{32'hDEAD_BEEF}};
      p4 = {5{32'h0F0F_0F0F}};
      p5 = {5{32'hCAFE_F00D}};
      reset = 1'b1; flush = 1'b0; hold = 1'b0;
      present('0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idValid = 1'b1;
      tick; tick;
      reset = 1'b0;
      chk("rst_pipe", pipeOut, '0);
      chk("rst_valid", exValid, 0);
      chk("rst_memrd", exMemRead, 0);
      chk("rst_dest", exDestReg, 0);
      chk("rst_cnt", bubbleCount, 0);

      present(p1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
      tick;
      chk("pass_pipe", pipeOut, p1);
      chk("pass_valid", exValid, 1);
      chk("pass_dest", exDestReg, 3);
      present(p2, 1'b0, 5'd4, 5'd3, 5'd0, 1'b0);
      chk("pass_nostall", stallIfId, 0);
      chk("pass_cnt", bubbleCount, 0);

      present(p1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
      tick;
      chk("lu_memrd", exMemRead, 1);
      present(p2, 1'b0, 5'd10, 5'd8, 5'd0, 1'b0);
      chk("lu_stall", stallIfId, 1);
      tick;
      chk("lu_bubble_valid", exValid, 0);
      chk("lu_bubble_pipe", pipeOut, '0);
      chk("lu_cnt", bubbleCount, 1);
      chk("lu_stall_clear", stallIfId, 0);
      tick;
      chk("lu_adv_pipe", pipeOut, p2);
      chk("lu_adv_dest", exDestReg, 10);

      present(p3, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
      tick;
      present(p4, 1'b0, 5'd11, 5'd1, 5'd9, 1'b0);
      chk("rt_gated", stallIfId, 0);
      present(p4, 1'b0, 5'd11, 5'd1, 5'd9, 1'b1);
      chk("rt_used", stallIfId, 1);
      tick;
      chk("rt_cnt", bubbleCount, 2);
      tick;
      chk("rt_adv_dest", exDestReg, 11);

      present(p3, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
      tick;
      chk("zero_memrd", exMemRead, 1);
      present(p4, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1);
      chk("zero_nostall", stallIfId, 0);

      present(p3, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
      tick;
      present(p4, 1'b0, 5'd2, 5'd8, 5'd0, 1'b0);
      flush = 1'b1;
      #1;
      chk("flush_stall", stallIfId, 1);
      tick;
      flush = 1'b0;
      chk("flush_valid", exValid, 0);
      chk("flush_pipe", pipeOut, '0);
      chk("flush_cnt", bubbleCount, 2);
      tick;
      chk("flush_adv", pipeOut, p4);

      present(p4, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
      tick;
      present(p5, 1'b0, 5'd12, 5'd8, 5'd0, 1'b0);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("hold_pipe", pipeOut, p4);
         chk("hold_valid", exValid, 1);
         chk("hold_stall", stallIfId, 1);
         chk("hold_cnt", bubbleCount, 2);
      end
      hold = 1'b0;
      tick;
      chk("hold_then_bubble", exValid, 0);
      chk("hold_then_cnt", bubbleCount, 3);
      tick;
      chk("hold_adv", pipeOut, p5);

      present(p1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
      tick;
      present(p2, 1'b1, 5'd6, 5'd5, 5'd0, 1'b0);
      chk("b2b_stall", stallIfId, 1);
      tick;
      chk("b2b_cnt", bubbleCount, 4);
      tick;
      chk("b2b_memrd", exMemRead, 1);
      chk("b2b_dest", exDestReg, 6);

      for (int i = 0; i < 20; i++) begin
         present(p3, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
         tick;
         present(p4, 1'b0, 5'd1, 5'd7, 5'd0, 1'b0);
         tick;
         if (i == 10) chk("sat_mid", bubbleCount, 15);
      end
      chk("sat_cnt", bubbleCount, 15);

      present(p3, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
      tick;
      present(p4, 1'b0, 5'd1, 5'd8, 5'd0, 1'b0);
      chk("rst_mid_stall", stallIfId, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rst_mid_valid", exValid, 0);
      chk("rst_mid_pipe", pipeOut, '0);
      chk("rst_mid_dest", exDestReg, 0);
      chk("rst_mid_cnt", bubbleCount, 0);
      chk("rst_mid_nostall", stallIfId, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
